// File: rtl/cm0_sys_reset_ctrl.sv
// System reset request controller: merges POR, SYSRESETREQ, watchdog and lockup
// into one minimum-width, flop-driven active-low SYSRSTn and records the reset cause.
module cm0_sys_reset_ctrl #(
    parameter int unsigned HOLD_CYCLES   = 16,
    parameter bit          LOCKUP_RST_EN = 1'b0,
    parameter bit          WDOG_PRESENT  = 1'b1
) (
    input  logic       CLK,
    input  logic       RSTIN,
    input  logic       RSTBYPASS,
    input  logic       SYSRESETREQ,
    input  logic       WDOGRESREQ,
    input  logic       LOCKUP,
    input  logic       CAUSE_CLR,
    output logic       SYSRSTn,
    output logic [3:0] RST_CAUSE,
    output logic       RST_BUSY
);

    localparam logic [7:0] CNT_LAST = 8'(HOLD_CYCLES - 1);

    typedef enum logic [1:0] {
        ST_RUN      = 2'd0,
        ST_ASSERT   = 2'd1,
        ST_WAIT_REL = 2'd2
    } state_t;

    state_t     state_q, state_d;
    logic [7:0] cnt_q, cnt_d;
    logic       sysrstn_q, sysrstn_d;
    logic [3:0] cause_q, cause_d;
    logic       busy_q;

    logic       lockup_m;
    logic       wdog_m;
    logic       req;
    logic [3:0] src;

    assign lockup_m = LOCKUP_RST_EN & LOCKUP;
    assign wdog_m   = WDOG_PRESENT & WDOGRESREQ;
    assign req      = SYSRESETREQ | wdog_m | lockup_m;
    assign src      = {1'b0, lockup_m, wdog_m, SYSRESETREQ};

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        sysrstn_d = sysrstn_q;
        cause_d   = cause_q;
        case (state_q)
            ST_RUN: begin
                sysrstn_d = 1'b1;
                if (req) begin
                    state_d   = ST_ASSERT;
                    cnt_d     = 8'd0;
                    sysrstn_d = 1'b0;
                    cause_d   = src;
                end else if (CAUSE_CLR) begin
                    cause_d = 4'b0000;
                end
            end
            ST_ASSERT: begin
                sysrstn_d = 1'b0;
                cause_d   = cause_q | src;
                // Counter parks at its last value, so it can never wrap.
                if (cnt_q == CNT_LAST) begin
                    if (req) begin
                        state_d = ST_WAIT_REL;
                    end else begin
                        state_d   = ST_RUN;
                        sysrstn_d = 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            ST_WAIT_REL: begin
                sysrstn_d = 1'b0;
                cause_d   = cause_q | src;
                if (!req) begin
                    state_d   = ST_RUN;
                    sysrstn_d = 1'b1;
                end
            end
            default: begin
                state_d   = ST_ASSERT;
                cnt_d     = 8'd0;
                sysrstn_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge CLK or negedge RSTIN) begin
        if (!RSTIN) begin
            state_q   <= ST_ASSERT;
            cnt_q     <= 8'd0;
            sysrstn_q <= 1'b0;
            cause_q   <= 4'b1000;
            busy_q    <= 1'b1;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            sysrstn_q <= sysrstn_d;
            cause_q   <= cause_d;
            busy_q    <= (state_d != ST_RUN);
        end
    end

    // Functional path is the bare flop; the bypass mux is a DFT-only override.
    assign SYSRSTn   = RSTBYPASS ? RSTIN : sysrstn_q;
    assign RST_CAUSE = cause_q;
    assign RST_BUSY  = busy_q;

endmodule

// File: tb/tb_cm0_sys_reset_ctrl.sv
// Bench for cm0_sys_reset_ctrl: two instances (lockup ignored / lockup enabled)
// checked every cycle against a "low cycles remaining" reference model.
module tb_cm0_sys_reset_ctrl;

    localparam int HOLD = 16;

    logic CLK = 1'b0;
    logic RSTIN = 1'b1;
    logic RSTBYPASS = 1'b0;
    logic SYSRESETREQ = 1'b0;
    logic WDOGRESREQ = 1'b0;
    logic LOCKUP = 1'b0;
    logic CAUSE_CLR = 1'b0;

    logic       sysrstn [2];
    logic [3:0] cause   [2];
    logic       busy    [2];

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model state per instance
    bit         m_rst   [2];
    int         m_left  [2];
    logic [3:0] m_cause [2];
    bit         lk_en   [2];

    always #5 CLK = ~CLK;

    cm0_sys_reset_ctrl #(.HOLD_CYCLES(HOLD), .LOCKUP_RST_EN(1'b0), .WDOG_PRESENT(1'b1)) dut0 (
        .CLK(CLK), .RSTIN(RSTIN), .RSTBYPASS(RSTBYPASS), .SYSRESETREQ(SYSRESETREQ),
        .WDOGRESREQ(WDOGRESREQ), .LOCKUP(LOCKUP), .CAUSE_CLR(CAUSE_CLR),
        .SYSRSTn(sysrstn[0]), .RST_CAUSE(cause[0]), .RST_BUSY(busy[0])
    );

    cm0_sys_reset_ctrl #(.HOLD_CYCLES(HOLD), .LOCKUP_RST_EN(1'b1), .WDOG_PRESENT(1'b1)) dut1 (
        .CLK(CLK), .RSTIN(RSTIN), .RSTBYPASS(RSTBYPASS), .SYSRESETREQ(SYSRESETREQ),
        .WDOGRESREQ(WDOGRESREQ), .LOCKUP(LOCKUP), .CAUSE_CLR(CAUSE_CLR),
        .SYSRSTn(sysrstn[1]), .RST_CAUSE(cause[1]), .RST_BUSY(busy[1])
    );

    task automatic check(input string tag, input logic [3:0] obs, input logic [3:0] exp);
        n_tests++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_por();
        for (int i = 0; i < 2; i++) begin
            m_rst[i]   = 1'b1;
            m_left[i]  = HOLD;
            m_cause[i] = 4'b1000;
        end
    endtask

    // One clock edge: a reset window lasts HOLD edges from its start and ends
    // only at an edge where no source is requesting.
    task automatic model_edge();
        logic [3:0] s;
        for (int i = 0; i < 2; i++) begin
            s = {1'b0, lk_en[i] & LOCKUP, WDOGRESREQ, SYSRESETREQ};
            if (RSTIN) begin
                if (!m_rst[i]) begin
                    if (s != 4'b0000) begin
                        m_rst[i]   = 1'b1;
                        m_left[i]  = HOLD;
                        m_cause[i] = s;
                    end else if (CAUSE_CLR) begin
                        m_cause[i] = 4'b0000;
                    end
                end else begin
                    m_cause[i] = m_cause[i] | s;
                    if (m_left[i] > 0) m_left[i]--;
                    if (m_left[i] == 0 && s == 4'b0000) m_rst[i] = 1'b0;
                end
            end
        end
    endtask

    task automatic check_all(input string tag);
        logic exp_n;
        for (int i = 0; i < 2; i++) begin
            exp_n = RSTBYPASS ? RSTIN : ~m_rst[i];
            check($sformatf("%s/u%0d/SYSRSTn", tag, i), {3'b0, sysrstn[i]}, {3'b0, exp_n});
            check($sformatf("%s/u%0d/CAUSE", tag, i), cause[i], m_cause[i]);
            check($sformatf("%s/u%0d/BUSY", tag, i), {3'b0, busy[i]}, {3'b0, m_rst[i]});
        end
    endtask

    task automatic step(input string tag, input int n = 1);
        for (int k = 0; k < n; k++) begin
            @(posedge CLK);
            model_edge();
            #1;
            check_all(tag);
        end
    endtask

    task automatic async_rst_pulse(input string tag, input int low_cycles);
        #2 RSTIN = 1'b0;
        model_por();
        #1 check_all({tag, "/async"});
        step(tag, low_cycles);
        RSTIN = 1'b1;
        #1 check_all({tag, "/rel"});
    endtask

    initial begin
        int low;
        lk_en[0] = 1'b0;
        lk_en[1] = 1'b1;

        // POR
        #2 RSTIN = 1'b0;
        model_por();
        #1 check_all("por_async");
        step("por_low", 5);
        RSTIN = 1'b1;
        step("por_hold", HOLD + 4);
        check("por_cause", cause[0], 4'b1000);

        // SYSRESETREQ one-cycle pulse: measure low width
        SYSRESETREQ = 1'b1;
        step("sreq_trig");
        SYSRESETREQ = 1'b0;
        low = 0;
        while (sysrstn[0] == 1'b0 && low < 100) begin
            low++;
            step("sreq_hold");
        end
        check("sreq_low_width", 4'(low), 4'(HOLD));
        check("sreq_low_width_hi", {3'b0, low > 15}, 4'b0001);
        check("sreq_cause", cause[0], 4'b0001);
        step("sreq_idle", 3);

        // Watchdog held 40 cycles
        WDOGRESREQ = 1'b1;
        step("wdog_held", 40);
        WDOGRESREQ = 1'b0;
        step("wdog_rel", 4);
        check("wdog_cause", cause[0], 4'b0010);

        // LOCKUP alone, then LOCKUP + SYSRESETREQ together
        LOCKUP = 1'b1;
        step("lockup", 3);
        LOCKUP = 1'b0;
        step("lockup_run", HOLD + 3);
        check("lockup_u0_cause", cause[0], 4'b0010);
        check("lockup_u1_cause", cause[1], 4'b0100);
        LOCKUP = 1'b1;
        SYSRESETREQ = 1'b1;
        step("lk_sreq");
        LOCKUP = 1'b0;
        SYSRESETREQ = 1'b0;
        step("lk_sreq_run", HOLD + 3);
        check("lk_sreq_u0_cause", cause[0], 4'b0001);
        check("lk_sreq_u1_cause", cause[1], 4'b0101);

        // CAUSE_CLR alone, then together with a trigger
        CAUSE_CLR = 1'b1;
        step("clr");
        CAUSE_CLR = 1'b0;
        step("clr_idle");
        check("clr_cause", cause[0], 4'b0000);
        CAUSE_CLR = 1'b1;
        SYSRESETREQ = 1'b1;
        step("clr_trig");
        CAUSE_CLR = 1'b0;
        SYSRESETREQ = 1'b0;
        step("clr_trig_hold", 4);
        CAUSE_CLR = 1'b1;
        step("clr_ignored", 2);
        CAUSE_CLR = 1'b0;
        step("clr_trig_run", HOLD);
        check("clr_trig_cause", cause[0], 4'b0001);

        // RSTIN pulse in the middle of a hold window
        SYSRESETREQ = 1'b1;
        step("mid_trig");
        SYSRESETREQ = 1'b0;
        step("mid_cnt", 7);
        async_rst_pulse("mid_por", 2);
        step("mid_hold", HOLD + 3);

        // DFT bypass
        RSTBYPASS = 1'b1;
        step("byp_idle", 2);
        async_rst_pulse("byp_por", 2);
        step("byp_hold", 5);
        check("byp_busy_hold", {3'b0, busy[0]}, 4'b0001);
        step("byp_run", HOLD);
        SYSRESETREQ = 1'b1;
        step("byp_sreq");
        SYSRESETREQ = 1'b0;
        step("byp_sreq_hold", 3);
        check("byp_sysrstn_high", {3'b0, sysrstn[0]}, 4'b0001);
        RSTBYPASS = 1'b0;
        step("byp_off", HOLD + 2);

        // Randomized traffic
        for (int c = 0; c < 3000; c++) begin
            SYSRESETREQ = ($urandom % 24 == 0);
            if ($urandom % 40 == 0) WDOGRESREQ = ~WDOGRESREQ;
            LOCKUP      = ($urandom % 30 == 0);
            CAUSE_CLR   = ($urandom % 6 == 0);
            RSTBYPASS   = ($urandom % 50 == 0);
            if ($urandom % 250 == 0) async_rst_pulse("rnd_por", 1 + int'($urandom % 3));
            step("rnd");
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
